// File: rtl/miriscv_apb_pkg.sv
// Types and address-map constants for the data-port APB bridge.
//   apb_state_e   : bridge FSM states
//   PERIPH_BIT    : address bit selecting the peripheral (APB) region
//   UART_IDX      : APB slave index of the UART
//   TIMER_IDX     : APB slave index of the timer
//   TIMEOUT_RDATA : read data returned when an APB access times out
//   sel_width()   : width of the slave-select field (never below 1)
package miriscv_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int unsigned PERIPH_BIT = 31;
  localparam int unsigned UART_IDX   = 0;
  localparam int unsigned TIMER_IDX  = 1;

  localparam logic [miriscv_pkg::XLEN-1:0] TIMEOUT_RDATA = miriscv_pkg::XLEN'(32'hDEAD_BEEF);

  function automatic int unsigned sel_width(input int unsigned n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide constants shared by the miriscv data-side blocks.
//   XLEN : machine word width in bits
package miriscv_pkg;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/miriscv_apb_decoder.sv
// Combinational APB slave decoder.
//   addr      : in  full core address
//   idx       : out slave index taken from addr[SEL_LSB +: SEL_W]
//   idx_valid : out index maps to an existing slave
//   sel       : out one-hot slave select, all zero when idx is invalid
module miriscv_apb_decoder
  import miriscv_pkg::*;
  import miriscv_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_LSB    = 12,
  parameter int unsigned SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [XLEN-1:0]       addr,
  output logic [SEL_W-1:0]      idx,
  output logic                  idx_valid,
  output logic [NUM_SLAVES-1:0] sel
);

  // Only the select field is decoded; the rest of the address is ignored here.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    idx       = addr[SEL_LSB +: SEL_W];
    idx_valid = (32'(idx) < NUM_SLAVES);
    sel       = idx_valid ? (NUM_SLAVES'(1) << idx) : '0;
  end

endmodule

// File: rtl/miriscv_data_apb_bridge.sv
// Data-port bridge: addr[31]==0 goes straight to the RAM data port, addr[31]==1 runs an
// APB4 transfer (SETUP/ACCESS with PREADY wait states and PSLVERR). One rvalid per request.
// Optional feature macro: MIRISCV_APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC
// cycles without PREADY, answering TIMEOUT_RDATA with err=1.
//   clk_i, arstn_i                 : clock, async active-low reset
//   data_*                         : core data port (req pulse in, rvalid/rdata/err out)
//   dmem_*                         : RAM data port (request fields wired from the core)
//   psel_o .. pstrb_o              : APB master outputs (address/data/strobe registered)
//   prdata_i, pready_i, pslverr_i  : per-slave APB responses
module miriscv_data_apb_bridge
  import miriscv_pkg::*;
  import miriscv_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 2,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       data_req_i,
  input  logic                       data_we_i,
  input  logic [XLEN/8-1:0]          data_be_i,
  input  logic [XLEN-1:0]            data_addr_i,
  input  logic [XLEN-1:0]            data_wdata_i,
  output logic                       data_rvalid_o,
  output logic [XLEN-1:0]            data_rdata_o,
  output logic                       data_err_o,
  output logic                       dmem_req_o,
  output logic                       dmem_we_o,
  output logic [XLEN/8-1:0]          dmem_be_o,
  output logic [XLEN-1:0]            dmem_addr_o,
  output logic [XLEN-1:0]            dmem_wdata_o,
  input  logic                       dmem_rvalid_i,
  input  logic [XLEN-1:0]            dmem_rdata_i,
  output logic [NUM_SLAVES-1:0]      psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [XLEN-1:0]            paddr_o,
  output logic [XLEN-1:0]            pwdata_o,
  output logic [XLEN/8-1:0]          pstrb_o,
  input  logic [NUM_SLAVES*XLEN-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]      pready_i,
  input  logic [NUM_SLAVES-1:0]      pslverr_i
);

  localparam int unsigned SEL_W = sel_width(NUM_SLAVES);

  apb_state_e              state_q, state_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic [XLEN/8-1:0]       pstrb_q, pstrb_d;
  logic                    we_q, we_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [SEL_W-1:0]        dec_idx;
  logic                    dec_valid;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    accept;

  miriscv_apb_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W)
  ) u_decoder (
    .addr      (data_addr_i),
    .idx       (dec_idx),
    .idx_valid (dec_valid),
    .sel       (dec_sel)
  );

  // RAM path is purely combinational.
  assign dmem_req_o   = data_req_i & ~data_addr_i[PERIPH_BIT];
  assign dmem_we_o    = data_we_i;
  assign dmem_be_o    = data_be_i;
  assign dmem_addr_o  = data_addr_i;
  assign dmem_wdata_o = data_wdata_i;

  // RESP is the last busy cycle, so a new request may already be taken there.
  assign accept = data_req_i & data_addr_i[PERIPH_BIT] & ((state_q == IDLE) | (state_q == RESP));

`ifdef MIRISCV_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th ACCESS cycle that still has no PREADY.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pstrb_d = pstrb_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          pstrb_d = data_we_i ? data_be_i : '0;
          we_d    = data_we_i;
          idx_d   = dec_idx;
          sel_d   = dec_sel;
          if (dec_valid) begin
            state_d = SETUP;
          end else begin
            // Unmapped slave: answer with an error and never touch the bus.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i[idx_q]) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : prdata_i[idx_q*XLEN +: XLEN];
          err_d   = pslverr_i[idx_q];
        end
`ifdef MIRISCV_APB_TIMEOUT_EN
        else if (timeout) begin
          state_d = RESP;
          rdata_d = TIMEOUT_RDATA;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pstrb_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pstrb_q <= pstrb_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    psel_o    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    penable_o = (state_q == ACCESS);
    pwrite_o  = we_q;
    paddr_o   = addr_q;
    pwdata_o  = wdata_q;
    pstrb_o   = pstrb_q;

    data_rvalid_o = dmem_rvalid_i | (state_q == RESP);
    data_err_o    = (state_q == RESP) & err_q;
    if (state_q == RESP) begin
      data_rdata_o = rdata_q;
    end else if (dmem_rvalid_i) begin
      data_rdata_o = dmem_rdata_i;
    end else begin
      data_rdata_o = '0;
    end
  end

  // The core must not issue a request while an APB transfer is in flight.
  assert property (@(posedge clk_i) disable iff (!arstn_i)
                   data_req_i |-> ((state_q == IDLE) || (state_q == RESP)));

  // RAM and APB responses never collide under the core protocol.
  assert property (@(posedge clk_i) disable iff (!arstn_i)
                   !(dmem_rvalid_i && (state_q == RESP)));

endmodule
